ext_mem_arbiter: RTL and testbench

Round-robin arbiter sharing the single external-memory native port between N burst-capable requesters: the CPU data path and the Versat DMA read/write channels. It sits in `ext_mem` in front of the cache/AXI bridge. It grants one requester at a time and holds the grant for a whole burst of `len+1` beats. It forwards that requester's native bus (valid/addr/wdata/wstrb/len/rdata/ready) to the memory port.

---
 rtl/ext_mem_arbiter_pkg.sv | 21 ++
 rtl/ext_mem_arbiter_rr_priority_enc.sv | 40 ++++
 rtl/ext_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_ext_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_arbiter_pkg.sv
// Shared widths and FSM encoding for the external-memory round-robin arbiter.
package ext_mem_arbiter_pkg;

  localparam int AXI_LEN_W = 8;
  localparam int MIG_BUS_W = 256;
  localparam int IO_ADDR_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Index of (start + offset) modulo n, with start < n and offset < n.
  function automatic int rr_wrap(input int start, input int offset, input int n);
    int p;
    p = start + offset;
    if (p >= n) p = p - n;
    return p;
  endfunction

endpackage

// File: rtl/ext_mem_arbiter_rr_priority_enc.sv
// Round-robin winner select: request vector rotated to start at last+1,
// then a fixed-priority encoder picks the first set bit.
module rr_priority_enc
  import ext_mem_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [N-1:0] rot;
  int           start;
  logic         found;

  always_comb begin
    start = (int'(last_i) >= N - 1) ? 0 : int'(last_i) + 1;
    rot   = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req_i[rr_wrap(start, i, N)];
    end

    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found     = 1'b1;
        gnt_idx_o = IDX_W'(rr_wrap(start, i, N));
        gnt_oh_o[rr_wrap(start, i, N)] = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Burst-granular round-robin arbiter sharing one native memory port among
// N requesters; the grant is held until len+1 beats have completed.
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = IO_ADDR_W,
  parameter int DATA_W    = MIG_BUS_W,
  parameter int LEN_W     = AXI_LEN_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  input  logic [N_MASTERS*LEN_W-1:0]      m_len,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  output logic [LEN_W-1:0]                s_len,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic [N_MASTERS-1:0]            grant,
  output logic                            busy
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int STB_W = DATA_W / 8;

  arb_state_e           state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     last_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     beat_cnt_q;
  logic                 busy_q;

  logic [N_MASTERS-1:0] win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;
  logic                 beat_done;

  rr_priority_enc #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i     (m_valid),
    .last_i    (last_q),
    .gnt_oh_o  (win_oh),
    .gnt_idx_o (win_idx),
    .any_o     (win_any)
  );

  assign beat_done = s_valid & s_ready;

  // Last beat is detected by comparing before incrementing, so len=2^LEN_W-1
  // runs the full 2^LEN_W beats without the counter wrapping into an early exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= IDX_W'(N_MASTERS - 1);
      grant_q    <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            owner_q    <= win_idx;
            last_q     <= win_idx;
            grant_q    <= win_oh;
            len_q      <= m_len[int'(win_idx)*LEN_W +: LEN_W];
            beat_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (beat_done) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == len_q) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    s_len   = '0;
    m_ready = '0;
    if (state_q == BURST) begin
      s_valid          = m_valid[owner_q];
      s_addr           = m_addr[int'(owner_q)*ADDR_W +: ADDR_W];
      s_wdata          = m_wdata[int'(owner_q)*DATA_W +: DATA_W];
      s_wstrb          = m_wstrb[int'(owner_q)*STB_W +: STB_W];
      s_len            = len_q;
      m_ready[owner_q] = s_ready;
    end
  end

  assign m_rdata = s_rdata;
  assign grant   = grant_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: a cycle table for the basic grant and
// round-robin behaviour, plus hand sequences for stalls, long bursts and reset.
module tb_ext_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_valid;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*SW-1:0]   m_wstrb;
  logic [N*LW-1:0]   m_len;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_ready;
  logic              s_valid;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [LW-1:0]     s_len;
  logic [DW-1:0]     s_rdata;
  logic              s_ready;
  logic [N-1:0]      grant;
  logic              busy;

  ext_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_len(m_len), .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_len(s_len), .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  valid;
    logic [LW-1:0] len;
    logic          sready;
    logic [N-1:0]  egrant;
    logic [N-1:0]  eready;
    logic          evalid;
    logic          ebusy;
  } vec_t;

  vec_t           tbl[15];
  logic [AW-1:0]  addr_pat[N];
  logic [DW-1:0]  wd_pat[N];
  logic [SW-1:0]  st_pat[N];
  int             nvec = 0;
  int             nfail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g == (N'(1) << i)) return i;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"},   DW'(grant),   '0);
    chk({tag, "_busy"},    DW'(busy),    '0);
    chk({tag, "_s_valid"}, DW'(s_valid), '0);
    chk({tag, "_m_ready"}, DW'(m_ready), '0);
    chk({tag, "_s_addr"},  DW'(s_addr),  '0);
    chk({tag, "_s_wdata"}, s_wdata,      '0);
    chk({tag, "_s_wstrb"}, DW'(s_wstrb), '0);
    chk({tag, "_s_len"},   DW'(s_len),   '0);
  endtask

  initial begin
    int  k, beats, b0;
    logic bad_g, bad_o, saw_idle;

    for (int i = 0; i < N; i++) begin
      addr_pat[i] = 32'h1000_0000 + AW'(i * 32'h100);
      wd_pat[i]   = {8{32'hD000_0000 + 32'(i)}};
    end
    st_pat[0] = '1;
    st_pat[1] = '0;
    st_pat[2] = 32'h0F0F_0F0F;
    m_addr  = {addr_pat[2], addr_pat[1], addr_pat[0]};
    m_wdata = {wd_pat[2], wd_pat[1], wd_pat[0]};
    m_wstrb = {st_pat[2], st_pat[1], st_pat[0]};

    //          valid   len    srdy  egrant  eready evld ebusy
    tbl[0]  = '{3'b100, 8'd3, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{3'b100, 8'd3, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1};
    tbl[2]  = '{3'b100, 8'd3, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1};
    tbl[3]  = '{3'b100, 8'd3, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1};
    tbl[4]  = '{3'b100, 8'd3, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1};
    tbl[5]  = '{3'b000, 8'd3, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[6]  = '{3'b111, 8'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[7]  = '{3'b111, 8'd0, 1'b1, 3'b001, 3'b001, 1'b1, 1'b1};
    tbl[8]  = '{3'b111, 8'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[9]  = '{3'b111, 8'd0, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1};
    tbl[10] = '{3'b111, 8'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[11] = '{3'b111, 8'd0, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1};
    tbl[12] = '{3'b111, 8'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[13] = '{3'b111, 8'd0, 1'b1, 3'b001, 3'b001, 1'b1, 1'b1};
    tbl[14] = '{3'b000, 8'd0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};

    rst = 1'b0; m_valid = '0; m_len = '0; s_ready = 1'b0; s_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("in_reset");
    @(posedge clk); #1 rst = 1'b1;

    // Idle after reset, no requests
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_s_valid", DW'(s_valid), '0);
      chk("idle_grant",   DW'(grant),   '0);
      chk("idle_busy",    DW'(busy),    '0);
    end

    // Table: single-master burst, then round-robin among all three
    for (int v = 0; v < 15; v++) begin
      @(posedge clk); #1;
      m_valid = tbl[v].valid;
      m_len   = {N{tbl[v].len}};
      s_ready = tbl[v].sready;
      s_rdata = {8{$urandom}};
      @(negedge clk);
      k = oh_idx(tbl[v].egrant);
      chk($sformatf("v%0d_grant", v),   DW'(grant),   DW'(tbl[v].egrant));
      chk($sformatf("v%0d_m_ready", v), DW'(m_ready), DW'(tbl[v].eready));
      chk($sformatf("v%0d_s_valid", v), DW'(s_valid), DW'(tbl[v].evalid));
      chk($sformatf("v%0d_busy", v),    DW'(busy),    DW'(tbl[v].ebusy));
      chk($sformatf("v%0d_s_addr", v),  DW'(s_addr),  (k < 0) ? '0 : DW'(addr_pat[k]));
      chk($sformatf("v%0d_s_wdata", v), s_wdata,      (k < 0) ? '0 : wd_pat[k]);
      chk($sformatf("v%0d_s_wstrb", v), DW'(s_wstrb), (k < 0) ? '0 : DW'(st_pat[k]));
      chk($sformatf("v%0d_s_len", v),   DW'(s_len),   tbl[v].ebusy ? DW'(tbl[v].len) : '0);
      chk($sformatf("v%0d_m_rdata", v), m_rdata,      s_rdata);
    end

    // Master 1, len 7, s_ready toggling, m_valid dropped for 3 cycles
    beats = 0; bad_g = 0; bad_o = 0; saw_idle = 0;
    for (int it = 0; it < 100; it++) begin
      @(posedge clk); #1;
      s_ready = (it % 2) == 1;
      m_valid = (beats < 8 && !(it >= 4 && it <= 6)) ? 3'b010 : 3'b000;
      m_len   = {N{8'd7}};
      @(negedge clk);
      b0 = beats;
      if (m_ready[0] !== 1'b0 || m_ready[2] !== 1'b0) bad_o = 1;
      if (b0 == 8) begin
        chk("stall_idle_grant", DW'(grant), '0);
        chk("stall_idle_busy",  DW'(busy),  '0);
        saw_idle = 1;
        break;
      end
      if (it >= 1 && (grant !== 3'b010 || busy !== 1'b1)) bad_g = 1;
      if (s_valid === 1'b1 && m_ready[1] === 1'b1) beats++;
    end
    chk("stall_beats",      DW'(beats),    DW'(8));
    chk("stall_grant_held", DW'(bad_g),    '0);
    chk("stall_others_rdy", DW'(bad_o),    '0);
    chk("stall_finished",   DW'(saw_idle), DW'(1));

    // Master 2, len 255, m_len changed after grant
    beats = 0; bad_g = 0; saw_idle = 0;
    for (int it = 0; it < 400; it++) begin
      @(posedge clk); #1;
      s_ready = 1'b1;
      m_valid = (beats < 256) ? 3'b100 : 3'b000;
      m_len   = (it == 0) ? {N{8'd255}} : '0;
      @(negedge clk);
      b0 = beats;
      if (b0 == 256) begin
        chk("long_idle_grant", DW'(grant), '0);
        saw_idle = 1;
        break;
      end
      if (it >= 1 && (grant !== 3'b100 || s_len !== 8'd255)) bad_g = 1;
      if (s_valid === 1'b1 && m_ready[2] === 1'b1) beats++;
    end
    chk("long_beats",    DW'(beats),    DW'(256));
    chk("long_held",     DW'(bad_g),    '0);
    chk("long_finished", DW'(saw_idle), DW'(1));

    // Reset asserted at beat 2 of a len 5 burst by master 1
    for (int it = 0; it < 4; it++) begin
      @(posedge clk); #1;
      s_ready = 1'b1;
      m_valid = 3'b010;
      m_len   = {N{8'd5}};
      if (it == 3) rst = 1'b0;
      @(negedge clk);
      if (it == 2) chk("rst_pre_grant", DW'(grant), DW'(3'b010));
    end
    check_all_zero("rst_now");
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("rst_next");
    @(posedge clk); #1;
    rst = 1'b1;
    m_valid = 3'b111;
    m_len = '0;
    @(negedge clk);
    chk("rst_rel_grant0", DW'(grant), '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rel_grant1", DW'(grant), DW'(3'b001));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
